// File: rtl/ifetch_if.sv
// ifetch_if: ROM Wishbone bus, decoder stream and redirect port of the fetch stage.
interface ifetch_if #(
    parameter int unsigned AW = 8
);
    logic [AW-1:0] wb_addr;
    logic [31:0]   wb_rdata;
    logic          wb_cyc;
    logic          wb_ack;
    logic          out_valid;
    logic [31:0]   out_data;
    logic [AW-1:0] out_pc;
    logic          out_ready;
    logic          redir_stb;
    logic [AW-1:0] redir_addr;

    // Fetch stage side
    modport master (
        output wb_addr, wb_cyc, out_valid, out_data, out_pc,
        input  wb_rdata, wb_ack, out_ready, redir_stb, redir_addr
    );

    // ROM / decoder / execute side
    modport slave (
        input  wb_addr, wb_cyc, out_valid, out_data, out_pc,
        output wb_rdata, wb_ack, out_ready, redir_stb, redir_addr
    );
endinterface

// File: rtl/ifetch.sv
// ifetch: Wishbone instruction fetch with PC, small output queue and redirect/discard.
// Build option: define IFETCH_PREFETCH_EN for a 2-entry prefetch queue;
// otherwise a 1-entry holding register is used.
module ifetch #(
    parameter int unsigned   AW         = 8,
    parameter logic [AW-1:0] RESET_ADDR = '0
) (
    input logic      clk,
    input logic      rst_n,
    ifetch_if.master bus
);
`ifdef IFETCH_PREFETCH_EN
    localparam int unsigned DEPTH = 2;
`else
    localparam int unsigned DEPTH = 1;
`endif
    localparam int unsigned CW      = 2;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic          cyc_q, cyc_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW-1:0] pc_q, pc_d;
    logic          discard_q, discard_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          valid_q, valid_d;
    logic [31:0]   data_q [2];
    logic [31:0]   data_d [2];
    logic [AW-1:0] tag_q  [2];
    logic [AW-1:0] tag_d  [2];

    logic          ack;
    logic          pop;
    logic          push;
    logic [CW-1:0] cnt_pop;

    // Next-state: queue shift/push, PC update, discard tracking and issue rule
    always_comb begin
        ack       = cyc_q & bus.wb_ack;
        pop       = valid_q & bus.out_ready;
        push      = ack & ~discard_q & ~bus.redir_stb;
        cnt_pop   = cnt_q - CW'(pop);
        cyc_d     = cyc_q;
        addr_d    = addr_q;
        pc_d      = pc_q;
        discard_d = discard_q;
        data_d    = data_q;
        tag_d     = tag_q;

        // Head leaves on transfer; the second slot slides forward
        if (pop) begin
            data_d[0] = data_q[1];
            tag_d[0]  = tag_q[1];
        end

        // Acked word lands behind whatever survives the pop
        if (push) begin
            if (cnt_pop == '0) begin
                data_d[0] = bus.wb_rdata;
                tag_d[0]  = addr_q;
            end else begin
                data_d[1] = bus.wb_rdata;
                tag_d[1]  = addr_q;
            end
        end
        cnt_d = cnt_pop + CW'(push);

        if (ack && !discard_q) begin
            pc_d = AW'(pc_q + 1'b1);
        end

        // Redirect wins over the increment and empties the queue
        if (bus.redir_stb) begin
            pc_d  = bus.redir_addr;
            cnt_d = '0;
        end

        // A stale request in flight must have its data thrown away on ack
        if (ack) begin
            discard_d = 1'b0;
        end else if (cyc_q && bus.redir_stb) begin
            discard_d = 1'b1;
        end

        // Address is frozen while a request is pending; re-evaluate only when free
        if (!cyc_q || ack) begin
            cyc_d = (cnt_d < DEPTH_C);
            if (cnt_d < DEPTH_C) begin
                addr_d = pc_d;
            end
        end

        valid_d = (cnt_d != '0);
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_q     <= 1'b0;
            addr_q    <= RESET_ADDR;
            pc_q      <= RESET_ADDR;
            discard_q <= 1'b0;
            cnt_q     <= '0;
            valid_q   <= 1'b0;
            data_q[0] <= '0;
            data_q[1] <= '0;
            tag_q[0]  <= '0;
            tag_q[1]  <= '0;
        end else begin
            cyc_q     <= cyc_d;
            addr_q    <= addr_d;
            pc_q      <= pc_d;
            discard_q <= discard_d;
            cnt_q     <= cnt_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            tag_q     <= tag_d;
        end
    end

    assign bus.wb_cyc    = cyc_q;
    assign bus.wb_addr   = addr_q;
    assign bus.out_valid = valid_q;
    assign bus.out_data  = data_q[0];
    assign bus.out_pc    = tag_q[0];
endmodule

// File: tb/tb_ifetch.sv
// tb_ifetch: directed tests of the fetch stage against a one-wait-state ROM model.
module tb_ifetch;
    localparam int unsigned AW = 8;
`ifdef IFETCH_PREFETCH_EN
    localparam int P = 2;
`else
    localparam int P = 3;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic rst1_n;
    int   tests_run    = 0;
    int   tests_failed = 0;
    int   cycle        = 0;

    always #5 clk = ~clk;

    ifetch_if #(.AW(AW)) bus0 ();
    ifetch_if #(.AW(AW)) bus1 ();

    ifetch #(.AW(AW), .RESET_ADDR(8'h00)) dut0 (.clk(clk), .rst_n(rst_n),  .bus(bus0));
    ifetch #(.AW(AW), .RESET_ADDR(8'hFE)) dut1 (.clk(clk), .rst_n(rst1_n), .bus(bus1));

    // ROM models: ack one cycle after cyc, never two in a row; word n = 0x1000_0000+n
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus0.wb_ack   <= 1'b0;
            bus0.wb_rdata <= '0;
        end else begin
            bus0.wb_ack   <= bus0.wb_cyc & ~bus0.wb_ack;
            bus0.wb_rdata <= 32'h1000_0000 + 32'(bus0.wb_addr);
        end
    end

    always @(posedge clk or negedge rst1_n) begin
        if (!rst1_n) begin
            bus1.wb_ack   <= 1'b0;
            bus1.wb_rdata <= '0;
        end else begin
            bus1.wb_ack   <= bus1.wb_cyc & ~bus1.wb_ack;
            bus1.wb_rdata <= 32'h1000_0000 + 32'(bus1.wb_addr);
        end
    end

    // Cycle k = state after the k-th rising edge following reset release
    task automatic tick();
        @(negedge clk);
        cycle++;
    endtask

    task automatic do_reset(input logic ready);
        rst_n          = 1'b0;
        bus0.out_ready = ready;
        bus0.redir_stb = 1'b0;
        bus0.redir_addr = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cycle = -1;
    endtask

    task automatic test_reset();
        rst_n          = 1'b0;
        bus0.out_ready = 1'b1;
        bus0.redir_stb = 1'b0;
        bus0.redir_addr = '0;
        repeat (2) @(negedge clk);
        tests_run++;
        if (bus0.wb_cyc !== 1'b0 || bus0.wb_addr !== 8'h00 || bus0.out_valid !== 1'b0 ||
            bus0.out_data !== 32'h0 || bus0.out_pc !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_values: cyc=%b addr=%h valid=%b data=%h pc=%h expected 0 00 0 0 00",
                     bus0.wb_cyc, bus0.wb_addr, bus0.out_valid, bus0.out_data, bus0.out_pc);
        end
        rst_n = 1'b1;
        cycle = -1;
        tick();
        tests_run++;
        if (bus0.wb_cyc !== 1'b1 || bus0.wb_addr !== 8'h00) begin
            tests_failed++;
            $display("FAIL first_issue: cyc=%b addr=%h expected 1 00", bus0.wb_cyc, bus0.wb_addr);
        end
        tick();
        tests_run++;
        if (bus0.out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL early_valid: valid=%b expected 0 at cycle 1", bus0.out_valid);
        end
        tick();
        tests_run++;
        if (bus0.out_valid !== 1'b1 || bus0.out_pc !== 8'h00 || bus0.out_data !== 32'h1000_0000) begin
            tests_failed++;
            $display("FAIL first_word: valid=%b pc=%h data=%h expected 1 00 10000000",
                     bus0.out_valid, bus0.out_pc, bus0.out_data);
        end
    endtask

    // Continues from cycle 2 of test_reset with out_ready held high
    task automatic test_stream();
        for (int k = 0; k < 4; k++) begin
            int n;
            n = 0;
            while (bus0.out_valid !== 1'b1 && n < 12) begin
                tick();
                n++;
            end
            tests_run++;
            if (bus0.out_valid !== 1'b1 || bus0.out_pc !== AW'(k) ||
                bus0.out_data !== 32'h1000_0000 + 32'(k) || cycle != 2 + k * P) begin
                tests_failed++;
                $display("FAIL stream_%0d: valid=%b pc=%h data=%h cycle=%0d expected 1 %h %h %0d",
                         k, bus0.out_valid, bus0.out_pc, bus0.out_data, cycle,
                         AW'(k), 32'h1000_0000 + 32'(k), 2 + k * P);
            end
            tick();
        end
    endtask

    task automatic test_stall();
        int got;
        do_reset(1'b0);
        repeat (3) tick();
        while (cycle < 11) tick();
        tests_run++;
        if (bus0.wb_cyc !== 1'b0 || bus0.out_valid !== 1'b1 || bus0.out_pc !== 8'h00) begin
            tests_failed++;
            $display("FAIL stall_hold: cyc=%b valid=%b pc=%h expected 0 1 00",
                     bus0.wb_cyc, bus0.out_valid, bus0.out_pc);
        end
        bus0.out_ready = 1'b1;
        got = 0;
        for (int n = 0; n < 40 && got < 4; n++) begin
            if (bus0.out_valid === 1'b1) begin
                tests_run++;
                if (bus0.out_pc !== AW'(got) || bus0.out_data !== 32'h1000_0000 + 32'(got)) begin
                    tests_failed++;
                    $display("FAIL stall_order_%0d: pc=%h data=%h expected %h %h", got,
                             bus0.out_pc, bus0.out_data, AW'(got), 32'h1000_0000 + 32'(got));
                end
                got++;
            end
            tick();
        end
        tests_run++;
        if (got != 4) begin
            tests_failed++;
            $display("FAIL stall_count: got %0d words expected 4", got);
        end
    endtask

    task automatic test_redirect_outstanding();
        int n;
        do_reset(1'b1);
        tick();
        tests_run++;
        if (bus0.wb_cyc !== 1'b1 || bus0.wb_ack !== 1'b0) begin
            tests_failed++;
            $display("FAIL redir_pending_pre: cyc=%b ack=%b expected 1 0", bus0.wb_cyc, bus0.wb_ack);
        end
        bus0.redir_stb  = 1'b1;
        bus0.redir_addr = 8'h40;
        tick();
        bus0.redir_stb = 1'b0;
        tests_run++;
        if (bus0.out_valid !== 1'b0 || bus0.wb_cyc !== 1'b1 || bus0.wb_addr !== 8'h00) begin
            tests_failed++;
            $display("FAIL redir_pending_r1: valid=%b cyc=%b addr=%h expected 0 1 00",
                     bus0.out_valid, bus0.wb_cyc, bus0.wb_addr);
        end
        tick();
        tests_run++;
        if (bus0.out_valid !== 1'b0 || bus0.wb_cyc !== 1'b1 || bus0.wb_addr !== 8'h40) begin
            tests_failed++;
            $display("FAIL redir_pending_r2: valid=%b cyc=%b addr=%h expected 0 1 40",
                     bus0.out_valid, bus0.wb_cyc, bus0.wb_addr);
        end
        tick();
        tests_run++;
        if (bus0.out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL redir_pending_r3: valid=%b expected 0", bus0.out_valid);
        end
        tick();
        tests_run++;
        if (bus0.out_valid !== 1'b1 || bus0.out_pc !== 8'h40 || bus0.out_data !== 32'h1000_0040) begin
            tests_failed++;
            $display("FAIL redir_pending_r4: valid=%b pc=%h data=%h expected 1 40 10000040",
                     bus0.out_valid, bus0.out_pc, bus0.out_data);
        end
        tick();
        n = 0;
        while (bus0.out_valid !== 1'b1 && n < 12) begin
            tick();
            n++;
        end
        tests_run++;
        if (bus0.out_valid !== 1'b1 || bus0.out_pc !== 8'h41 || cycle != 4 + P) begin
            tests_failed++;
            $display("FAIL redir_pending_next: valid=%b pc=%h cycle=%0d expected 1 41 %0d",
                     bus0.out_valid, bus0.out_pc, cycle, 4 + P);
        end
    endtask

    task automatic test_redirect_ack();
        do_reset(1'b1);
        repeat (2) tick();
        tests_run++;
        if (bus0.wb_ack !== 1'b1) begin
            tests_failed++;
            $display("FAIL redir_ack_pre: ack=%b expected 1", bus0.wb_ack);
        end
        bus0.redir_stb  = 1'b1;
        bus0.redir_addr = 8'h40;
        tick();
        bus0.redir_stb = 1'b0;
        tests_run++;
        if (bus0.wb_cyc !== 1'b1 || bus0.wb_addr !== 8'h40 || bus0.out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL redir_ack_r1: cyc=%b addr=%h valid=%b expected 1 40 0",
                     bus0.wb_cyc, bus0.wb_addr, bus0.out_valid);
        end
        tick();
        tests_run++;
        if (bus0.out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL redir_ack_r2: valid=%b expected 0", bus0.out_valid);
        end
        tick();
        tests_run++;
        if (bus0.out_valid !== 1'b1 || bus0.out_pc !== 8'h40 || bus0.out_data !== 32'h1000_0040) begin
            tests_failed++;
            $display("FAIL redir_ack_r3: valid=%b pc=%h data=%h expected 1 40 10000040",
                     bus0.out_valid, bus0.out_pc, bus0.out_data);
        end
    endtask

    task automatic test_redirect_flush();
        int n;
        do_reset(1'b0);
        repeat (3) tick();
        tests_run++;
        if (bus0.out_valid !== 1'b1 || bus0.out_pc !== 8'h00) begin
            tests_failed++;
            $display("FAIL flush_pre: valid=%b pc=%h expected 1 00", bus0.out_valid, bus0.out_pc);
        end
        bus0.redir_stb  = 1'b1;
        bus0.redir_addr = 8'h80;
        tick();
        bus0.redir_stb = 1'b0;
        bus0.out_ready = 1'b1;
        tests_run++;
        if (bus0.out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_r1: valid=%b expected 0", bus0.out_valid);
        end
        n = 0;
        while (bus0.out_valid !== 1'b1 && n < 12) begin
            tick();
            n++;
        end
        tests_run++;
        if (bus0.out_valid !== 1'b1 || bus0.out_pc !== 8'h80 || bus0.out_data !== 32'h1000_0080 ||
            cycle != ((P == 2) ? 6 : 5)) begin
            tests_failed++;
            $display("FAIL flush_target: valid=%b pc=%h data=%h cycle=%0d expected 1 80 10000080 %0d",
                     bus0.out_valid, bus0.out_pc, bus0.out_data, cycle, (P == 2) ? 6 : 5);
        end
    endtask

    task automatic test_reset_addr();
        logic [7:0] exp_pc [4];
        int got;
        exp_pc[0] = 8'hFE;
        exp_pc[1] = 8'hFF;
        exp_pc[2] = 8'h00;
        exp_pc[3] = 8'h01;
        @(negedge clk);
        rst1_n = 1'b1;
        got = 0;
        for (int n = 0; n < 40 && got < 4; n++) begin
            @(negedge clk);
            if (bus1.out_valid === 1'b1) begin
                tests_run++;
                if (bus1.out_pc !== exp_pc[got] || bus1.out_data !== 32'h1000_0000 + 32'(exp_pc[got])) begin
                    tests_failed++;
                    $display("FAIL reset_addr_%0d: pc=%h data=%h expected %h %h", got,
                             bus1.out_pc, bus1.out_data, exp_pc[got], 32'h1000_0000 + 32'(exp_pc[got]));
                end
                got++;
            end
        end
        tests_run++;
        if (got != 4) begin
            tests_failed++;
            $display("FAIL reset_addr_count: got %0d words expected 4", got);
        end
    endtask

    task automatic test_async_reset();
        do_reset(1'b0);
        repeat (3) tick();
        tests_run++;
        if (bus0.out_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL async_pre: valid=%b expected 1", bus0.out_valid);
        end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (bus0.wb_cyc !== 1'b0 || bus0.out_valid !== 1'b0 || bus0.wb_addr !== 8'h00 ||
            bus0.out_pc !== 8'h00 || bus0.out_data !== 32'h0) begin
            tests_failed++;
            $display("FAIL async_reset: cyc=%b valid=%b addr=%h pc=%h data=%h expected 0 0 00 00 0",
                     bus0.wb_cyc, bus0.out_valid, bus0.wb_addr, bus0.out_pc, bus0.out_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus0.out_ready = 1'b1;
        cycle = -1;
        tick();
        tests_run++;
        if (bus0.wb_cyc !== 1'b1 || bus0.wb_addr !== 8'h00) begin
            tests_failed++;
            $display("FAIL async_restart_issue: cyc=%b addr=%h expected 1 00", bus0.wb_cyc, bus0.wb_addr);
        end
        repeat (2) tick();
        tests_run++;
        if (bus0.out_valid !== 1'b1 || bus0.out_pc !== 8'h00 || bus0.out_data !== 32'h1000_0000) begin
            tests_failed++;
            $display("FAIL async_restart_word: valid=%b pc=%h data=%h expected 1 00 10000000",
                     bus0.out_valid, bus0.out_pc, bus0.out_data);
        end
    endtask

    initial begin
        rst_n           = 1'b0;
        rst1_n          = 1'b0;
        bus0.out_ready  = 1'b1;
        bus0.redir_stb  = 1'b0;
        bus0.redir_addr = '0;
        bus1.out_ready  = 1'b1;
        bus1.redir_stb  = 1'b0;
        bus1.redir_addr = '0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect_outstanding();
        test_redirect_ack();
        test_redirect_flush();
        test_reset_addr();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/ifetch.md
# ifetch

Instruction fetch stage for the soft core. It is the Wishbone master that drives the 256x32 instruction ROM, maintains the fetch PC, and buffers returned words. It presents them to the decoder over a valid/ready stream tagged with their word address. It also accepts branch/jump redirects from execute and discards stale in-flight and buffered words.

## Interface
- `AW`, 8: word-address width; must match the ROM.
- `RESET_ADDR`, 0: first word address fetched after reset.
- `clk` in 1: sole clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `wb_addr` out AW: ROM word address; registered.
- `wb_rdata` in 32: ROM read data; valid in the cycle `wb_ack`=1.
- `wb_cyc` out 1: request; registered.
- `wb_ack` in 1: ROM acknowledge.
- `out_valid` out 1: `out_data`/`out_pc` valid.
- `out_data` out 32: instruction word.
- `out_pc` out AW: word address of `out_data`.
- `out_ready` in 1: decoder accepts; a transfer occurs when `out_valid & out_ready`.
- `redir_stb` in 1: redirect request, single-cycle.
- `redir_addr` in AW: redirect target word address.

## Operation
- Reset values:
  - `wb_cyc`=0, `wb_addr`=`RESET_ADDR`, `out_valid`=0, `out_data`=0, `out_pc`=0.
  - Internal fetch PC=`RESET_ADDR`, queue empty, discard flag=0.
- ROM protocol:
  - `wb_addr` is held constant while `wb_cyc`=1 until `wb_ack`.
  - The ROM acks one cycle after `wb_cyc` is seen and never acks two consecutive cycles, so the peak rate is one word per 2 cycles.
- Issue rule: a request is issued when occupancy (queued words + outstanding request) < DEPTH.
  - DEPTH is 2 with `IFETCH_PREFETCH_EN`, otherwise 1.
  - At most one request is outstanding.
- On `wb_ack` with discard=0:
  - Push {`wb_rdata`, `wb_addr`} into the queue.
  - PC increments modulo 2^AW, so address 2^AW-1 wraps to 0.
  - If the issue rule still holds (occupancy counted after the push and any same-cycle pop), keep `wb_cyc`=1 and load `wb_addr`<=PC; otherwise drop `wb_cyc`.
- On `wb_ack` with discard=1:
  - Drop the data and clear discard.
  - Issue to the current PC (the redirect target).
- Queue:
  - FIFO; the head drives `out_*`.
  - Pop on transfer.
  - Push and pop in the same cycle are allowed when full.
- Redirect (`redir_stb`=1):
  - PC<=`redir_addr`.
  - The queue is flushed, so `out_valid`=0 the next cycle. A transfer in the same cycle still counts as accepted.
  - If a request is outstanding and `wb_ack`=0 this cycle: set discard and keep `wb_cyc`/`wb_addr` unchanged until ack.
  - If `wb_ack`=1 this cycle: drop the acked word and issue `redir_addr` next cycle.
  - If idle: issue `redir_addr` next cycle.
- A second redirect while discard=1 only updates PC; discard stays 1.
- Asserting `rst_n` low mid-transaction returns everything to reset values immediately, without waiting for ack.

## Timing
- First release edge of `rst_n`, cycle 0: `wb_cyc`=1, `wb_addr`=`RESET_ADDR`.
- Cycle 1: `wb_ack`. Cycle 2: `out_valid`=1, `out_pc`=`RESET_ADDR`.
- Redirect at cycle R with no outstanding request:
  - R+1: `wb_cyc`=1, `wb_addr`=`redir_addr`.
  - R+2: ack.
  - R+3: `out_valid` with the target word.
- Redirect with a request outstanding, unacked: the stale ack arrives at R+1 and the target word appears at `out_*` at R+4.
- Outputs are registered; no combinational path from `out_ready` or `redir_stb` to `wb_*`.

## Configuration
- `IFETCH_PREFETCH_EN` defined: 2-entry queue.
  - Fetching continues while the decoder stalls for one word.
  - Sustained rate is 1 word / 2 cycles with `out_ready`=1.
- `IFETCH_PREFETCH_EN` undefined: 1-entry holding register.
  - The next request issues only after the held word is popped.
  - Sustained rate is 1 word / 3 cycles.
  - Redirect and discard behaviour is identical.

## Test plan
- Reset release, ROM word n = 0x1000_0000+n, `out_ready`=1: `out_pc` sequence 0,1,2,3 with matching data; first `out_valid` at cycle 2; one transfer every 2 cycles (prefetch) or 3 cycles (no prefetch).
- `out_ready`=0 for 10 cycles after the first valid: `wb_cyc` drops after occupancy reaches DEPTH; no word is lost or duplicated after release.
- `redir_stb` with `redir_addr`=0x40 while a request is outstanding: the stale word is never output; the next `out_pc`=0x40 at R+4; the queue was flushed at R+1.
- `redir_stb` in the same cycle as `wb_ack`: the acked word is dropped; `wb_addr`=target at R+1.
- `RESET_ADDR`=0xFE: the `out_pc` sequence is 0xFE, 0xFF, 0x00, 0x01.
- `rst_n` low during an outstanding request: `wb_cyc`=0 and `out_valid`=0 immediately; after release, fetch restarts at `RESET_ADDR`.
